banked_address_decoding: RTL
============================

# banked_address_decoding

Registered, parametrised PET address decoder supporting the 8096-style 64 KB RAM expansion. Sits between the bus arbiter and the SRAM/IO chip selects. Decodes each strobed bus access into one-hot device enables and a physical RAM address one cycle later. Owns the write-only expansion control register at `CTRL_ADDR`.

## Interface
- `EXPANSION`, 1: 1 = banked 8096 map with control register; 0 = fixed base map, register tied to 0.
- `RAM_ADDR_WIDTH`, 17: physical SRAM address width; must be ≥17.
- `CTRL_ADDR`, 16'hFFF0: CPU address of the control register.

Reset and clock: one clock; reset is synchronous and active-low.

- `clk_i` in 1: system clock.
- `reset_n_i` in 1: synchronous active-low reset.
- `bus_addr_i` in 17: bit16=1 means a host/physical access; bit16=0 means a CPU address in [15:0].
- `bus_data_i` in 8: write data, used only for control-register writes.
- `bus_we_i` in 1: 1 = write.
- `strobe_i` in 1: access valid this cycle.
- `valid_o` out 1: one-cycle pulse; decode outputs updated.
- `ram_addr_o` out RAM_ADDR_WIDTH: physical SRAM address.
- `ram_en_o`, `magic_en_o`, `pia1_en_o`, `pia2_en_o`, `via_en_o`, `crtc_en_o`, `io_en_o` out 1 each: device enables.
- `is_mirrored_o` out 1: access targets display RAM.
- `is_readonly_o` out 1: writes must be suppressed.
- `ctrl_o` out 8: current control register.

## Operation
- Base map, CPU address:
  - $0000-$7FFF: RAM.
  - $8000-$8FFF: RAM with mirrored=1.
  - $9000-$E7FF and $E900-$FFFF: RAM with readonly=1.
  - $E800-$E80F: magic.
  - $E810-$E81F: pia1 + io.
  - $E820-$E83F: pia2 + io.
  - $E840-$E87F: via + io.
  - $E880-$E8FF: crtc + io.
  - Base-map RAM hits: `ram_addr_o` = zero-extended CPU address.
- Host access (bit16=1): `ram_en`=1, `ram_addr_o` = zero-extended `bus_addr_i`, all other outputs 0. Never a control-register write.
- Control register bits:
  - [7] expansion enable.
  - [6] I/O peek-through ($E800-$EFFF).
  - [5] screen peek-through ($8000-$8FFF).
  - [3] $C000-$FFFF block select.
  - [2] $8000-$BFFF block select.
  - [1] write-protect $C000-$FFFF.
  - [0] write-protect $8000-$BFFF.
  - [4] stored, no effect.
- Banked map applies when EXPANSION=1, ctrl[7]=1, and CPU address ≥$8000, unless a peek-through bit covers the address (then the base map applies).
  - Enables: `ram_en`=1 only; mirrored=0.
  - $8000-$BFFF: block = ctrl[2] ? 2 : 0; readonly = ctrl[0].
  - $C000-$FFFF: block = ctrl[3] ? 3 : 1; readonly = ctrl[1].
  - `ram_addr_o` = $10000 + block×$4000 + addr[13:0].
- Control write: strobe_i & bus_we_i & bit16=0 & addr==CTRL_ADDR & EXPANSION=1.
  - Register loads `bus_data_i`.
  - Decode outputs for that access: all enables 0, `valid_o` pulses.
- Read of CTRL_ADDR decodes normally through the current map.
- EXPANSION=0: `ctrl_o`≡0; CTRL_ADDR decodes as readonly RAM.

## Timing
- Reset values: all enables 0, `ram_addr_o`=0, mirrored/readonly 0, `valid_o`=0, `ctrl_o`=0. Post-reset map equals the base map.
- Latency: inputs sampled on the rising edge with `strobe_i`=1; outputs and `valid_o`=1 appear after that edge (1 cycle).
- Outputs hold until the next strobe. `valid_o` deasserts when no strobe is present.
- Back-to-back strobes are supported every cycle; throughput is one access per cycle.
- A control write at edge N affects decode of accesses sampled at edge N+1 onward. The write's own decode (all enables 0) does not depend on the old value.
- Reset asserted mid-stream: the next edge forces reset values and clears `ctrl_o`. Strobes during reset are discarded.
- Address wrap: $FFFF in block 3 → physical $1FFFF. No carry beyond bit 16. Bits above 16 of `ram_addr_o` are 0.

## Structure
- Package `pet_map_pkg` contains:
  - Region boundary constants.
  - Ctrl bit index localparams.
  - `EXP_BASE`=17'h10000.
  - `typedef struct packed` `decode_t` holding all enables, mirrored, readonly, and ram_addr.
- Sub-module `base_map_decode`: combinational CPU-address → `decode_t` for the base map.
- Top level contains: the control register, the banking override mux, and the output register stage.

## Test plan
- Reset, then strobe reads of $0000/$8000/$9000/$E810/$E880/$F000: one cycle later, enables and flags match the base map. `ram_addr_o` equals the address; `valid_o` is a single pulse each.
- Write $80 to $FFF0, then read $8123: `ram_addr_o`=$10123, mirrored=0. Then read $C123: `ram_addr_o`=$14123.
- Write $8F, then read $8000 and $FFFF: addresses $18000 and $1FFFF, both readonly=1.
- Write $E0, then read $8400 and $E840: base map applies (mirrored RAM $8400; via+io). Read $9000: `ram_addr_o`=$11000.
- Back-to-back strobes: write $80 to $FFF0, then read $8000 on the next cycle: the read uses the banked map. Assert `reset_n_i`=0 for one cycle, then read $8000: base map, `ctrl_o`=0.
- Host access $1ABCD with ctrl=$80: `ram_en`=1, `ram_addr_o`=$1ABCD, `ctrl_o` unchanged. With EXPANSION=0, a write to $FFF0 leaves `ctrl_o`=0 and gives readonly=1.

Source files
------------

// File: rtl/pet_map_pkg.sv
// Shared PET memory-map constants, control-register bit positions and the
// decode record passed between the base-map decoder and the banked top level.
package pet_map_pkg;

    localparam logic [15:0] LOW_RAM_HI   = 16'h7FFF;
    localparam logic [15:0] SCREEN_LO    = 16'h8000;
    localparam logic [15:0] SCREEN_HI    = 16'h8FFF;
    localparam logic [15:0] IO_LO        = 16'hE800;
    localparam logic [15:0] MAGIC_HI     = 16'hE80F;
    localparam logic [15:0] PIA1_HI      = 16'hE81F;
    localparam logic [15:0] PIA2_HI      = 16'hE83F;
    localparam logic [15:0] VIA_HI       = 16'hE87F;
    localparam logic [15:0] IO_HI        = 16'hE8FF;
    localparam logic [15:0] PEEK_IO_LO   = 16'hE800;
    localparam logic [15:0] PEEK_IO_HI   = 16'hEFFF;
    localparam logic [15:0] BANK_LO_BASE = 16'h8000;
    localparam logic [15:0] BANK_HI_BASE = 16'hC000;

    localparam int CTRL_EXP_EN   = 7;
    localparam int CTRL_PEEK_IO  = 6;
    localparam int CTRL_PEEK_SCR = 5;
    localparam int CTRL_SEL_HI   = 3;
    localparam int CTRL_SEL_LO   = 2;
    localparam int CTRL_WP_HI    = 1;
    localparam int CTRL_WP_LO    = 0;

    localparam int          PHYS_W   = 17;
    localparam logic [16:0] EXP_BASE = 17'h10000;

    typedef struct packed {
        logic              ram_en;
        logic              magic_en;
        logic              pia1_en;
        logic              pia2_en;
        logic              via_en;
        logic              crtc_en;
        logic              io_en;
        logic              mirrored;
        logic              readonly;
        logic [PHYS_W-1:0] ram_addr;
    } decode_t;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/base_map_decode.sv
// Combinational decode of a 16-bit CPU address through the fixed (unbanked)
// PET map; used directly when banking is off or a peek-through window applies.
module base_map_decode
    import pet_map_pkg::*;
(
    input  logic [15:0] cpu_addr_i,
    output decode_t     dec_o
);

    always_comb begin
        dec_o          = '0;
        dec_o.ram_addr = {1'b0, cpu_addr_i};
        if (cpu_addr_i <= LOW_RAM_HI) begin
            dec_o.ram_en = 1'b1;
        end else if (in_range(cpu_addr_i, SCREEN_LO, SCREEN_HI)) begin
            dec_o.ram_en   = 1'b1;
            dec_o.mirrored = 1'b1;
        end else if (in_range(cpu_addr_i, IO_LO, IO_HI)) begin
            // Every I/O window except the magic page also raises the shared io strobe.
            if (cpu_addr_i <= MAGIC_HI) begin
                dec_o.magic_en = 1'b1;
            end else if (cpu_addr_i <= PIA1_HI) begin
                dec_o.pia1_en = 1'b1;
                dec_o.io_en   = 1'b1;
            end else if (cpu_addr_i <= PIA2_HI) begin
                dec_o.pia2_en = 1'b1;
                dec_o.io_en   = 1'b1;
            end else if (cpu_addr_i <= VIA_HI) begin
                dec_o.via_en = 1'b1;
                dec_o.io_en  = 1'b1;
            end else begin
                dec_o.crtc_en = 1'b1;
                dec_o.io_en   = 1'b1;
            end
        end else begin
            dec_o.ram_en   = 1'b1;
            dec_o.readonly = 1'b1;
        end
    end

endmodule

// File: rtl/banked_address_decoding.sv
// PET address decoder with 8096-style 64 KB expansion: owns the control
// register, overlays the banked map on the base map, and registers the result.
module banked_address_decoding
    import pet_map_pkg::*;
#(
    parameter int          EXPANSION      = 1,
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter logic [15:0] CTRL_ADDR      = 16'hFFF0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [16:0]               bus_addr_i,
    input  logic [7:0]                bus_data_i,
    input  logic                      bus_we_i,
    input  logic                      strobe_i,
    output logic                      valid_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                      ram_en_o,
    output logic                      magic_en_o,
    output logic                      pia1_en_o,
    output logic                      pia2_en_o,
    output logic                      via_en_o,
    output logic                      crtc_en_o,
    output logic                      io_en_o,
    output logic                      is_mirrored_o,
    output logic                      is_readonly_o,
    output logic [7:0]                ctrl_o
);

    logic [15:0] w_cpu_addr;
    logic        w_host;
    logic        w_ctrl_wr;
    logic        w_peek;
    logic        w_banked;
    logic        w_hi_half;
    logic [1:0]  w_block;
    decode_t     w_base;
    decode_t     w_next;

    logic [7:0]  r_ctrl;
    decode_t     r_dec_p1;
    logic        r_vld_p1;

    assign w_cpu_addr = bus_addr_i[15:0];
    assign w_host     = bus_addr_i[16];

    base_map_decode u_base_map (
        .cpu_addr_i (w_cpu_addr),
        .dec_o      (w_base)
    );

    assign w_ctrl_wr = (EXPANSION != 0) && strobe_i && bus_we_i && !w_host
                       && (w_cpu_addr == CTRL_ADDR);

    assign w_peek = (r_ctrl[CTRL_PEEK_IO]  && in_range(w_cpu_addr, PEEK_IO_LO, PEEK_IO_HI))
                 || (r_ctrl[CTRL_PEEK_SCR] && in_range(w_cpu_addr, SCREEN_LO, SCREEN_HI));

    assign w_banked  = (EXPANSION != 0) && r_ctrl[CTRL_EXP_EN]
                       && (w_cpu_addr >= BANK_LO_BASE) && !w_peek;
    assign w_hi_half = (w_cpu_addr >= BANK_HI_BASE);

    always_comb begin
        w_block = 2'd0;
        if (w_hi_half) begin
            w_block = r_ctrl[CTRL_SEL_HI] ? 2'd3 : 2'd1;
        end else begin
            w_block = r_ctrl[CTRL_SEL_LO] ? 2'd2 : 2'd0;
        end
    end

    // Priority: control write, then host access, then banked overlay, then base map.
    always_comb begin
        w_next = w_base;
        if (w_ctrl_wr) begin
            w_next = '0;
        end else if (w_host) begin
            w_next          = '0;
            w_next.ram_en   = 1'b1;
            w_next.ram_addr = bus_addr_i;
        end else if (w_banked) begin
            w_next          = '0;
            w_next.ram_en   = 1'b1;
            w_next.readonly = w_hi_half ? r_ctrl[CTRL_WP_HI] : r_ctrl[CTRL_WP_LO];
            w_next.ram_addr = EXP_BASE | {1'b0, w_block, w_cpu_addr[13:0]};
        end
    end

    // Output register stage (p1).
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ctrl   <= '0;
            r_dec_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= strobe_i;
            if (strobe_i) begin
                r_dec_p1 <= w_next;
            end
            if (w_ctrl_wr) begin
                r_ctrl <= bus_data_i;
            end
        end
    end

    assign valid_o       = r_vld_p1;
    assign ram_addr_o    = RAM_ADDR_WIDTH'(r_dec_p1.ram_addr);
    assign ram_en_o      = r_dec_p1.ram_en;
    assign magic_en_o    = r_dec_p1.magic_en;
    assign pia1_en_o     = r_dec_p1.pia1_en;
    assign pia2_en_o     = r_dec_p1.pia2_en;
    assign via_en_o      = r_dec_p1.via_en;
    assign crtc_en_o     = r_dec_p1.crtc_en;
    assign io_en_o       = r_dec_p1.io_en;
    assign is_mirrored_o = r_dec_p1.mirrored;
    assign is_readonly_o = r_dec_p1.readonly;
    assign ctrl_o        = r_ctrl;

endmodule
